// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared FSM state type, width helper and one-hot decode for the register write arbiter.
package reg_arb_pkg;
  typedef enum logic {IDLE, WRITE} state_e;
  localparam int OH_W = 64;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [OH_W-1:0] onehot(input int idx, input int n);
    onehot = '0;
    if (idx >= 0 && idx < n && idx < OH_W) onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; first set request at ptr, ptr+1, ... (mod N).
//   req_i   in  N   request vector
//   ptr_i   in  PW  search start index
//   idx_o   out PW  winning requester
//   valid_o out 1   any request present
module rr_pick #(
  parameter int N = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    idx_o = '0;
    valid_o = |req_i;
    // Walk from farthest to nearest so the requester closest to ptr wins last.
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = PW'((int'(ptr_i) + k) % N);
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin sharing of a register bank write port among NREQ requesters.
//   clk_i    in  1           clock, rising edge
//   reset_i  in  1           synchronous active-high reset
//   req_i    in  NREQ        per-requester write request
//   addr_i   in  NREQ*AW     packed register index per requester
//   data_i   in  NREQ*WIDTH  packed write data per requester
//   lock_i   in  NREQ        keep grant for back-to-back writes (only with REG_ARB_LOCK_EN)
//   ack_o    out NREQ        one-hot write-complete pulse
//   load_o   out NREG        one-hot register load enable
//   wdata_o  out WIDTH       data to the bank, holds outside writes
//   err_o    out 1           pulse when the granted address is out of range
//   busy_o   out 1           high in WRITE
// Optional feature macro: REG_ARB_LOCK_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 16,
  parameter int NREG = 8,
  localparam int AW = idx_w(NREG)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*AW-1:0]    addr_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock_i,
`endif
  output logic [NREQ-1:0]       ack_o,
  output logic [NREG-1:0]       load_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic                  err_o,
  output logic                  busy_o
);
  localparam int PW = idx_w(NREQ);
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, win;
  logic any, in_range, hold;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREG-1:0] load_q, load_d;
  logic [WIDTH-1:0] wdata_q, wdata_d, sel_data;
  logic [AW-1:0] sel_addr;
  logic err_q, err_d, busy_q, busy_d;
  logic [OH_W-1:0] oh_ack, oh_load;
  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .idx_o  (win),
    .valid_o(any)
  );
  // Outputs are decoded at the grant edge so they are registered yet appear in the WRITE cycle.
  always_comb begin
    sel_addr = addr_i[int'(win)*AW +: AW];
    sel_data = data_i[int'(win)*WIDTH +: WIDTH];
    in_range = int'(sel_addr) < NREG;
    oh_ack = onehot(int'(win), NREQ);
    oh_load = in_range ? onehot(int'(sel_addr), NREG) : '0;
`ifdef REG_ARB_LOCK_EN
    hold = lock_i[win_q] & req_i[win_q];
`else
    hold = 1'b0;
`endif
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    ack_d = '0;
    load_d = '0;
    err_d = 1'b0;
    busy_d = 1'b0;
    wdata_d = wdata_q;
    if (state_q == IDLE && any) begin
      state_d = WRITE;
      win_d = win;
      busy_d = 1'b1;
      ack_d = oh_ack[NREQ-1:0];
      load_d = oh_load[NREG-1:0];
      err_d = !in_range;
      wdata_d = in_range ? sel_data : wdata_q;
    end else if (state_q == WRITE) begin
      state_d = IDLE;
      ptr_d = hold ? win_q : (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      ack_q <= '0;
      load_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      ack_q <= ack_d;
      load_q <= load_d;
      err_q <= err_d;
      busy_q <= busy_d;
      wdata_q <= wdata_d;
    end
  end
  assign ack_o = ack_q;
  assign load_o = load_q;
  assign err_o = err_q;
  assign busy_o = busy_q;
  assign wdata_o = wdata_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench with a cycle-level reference model of the arbiter.
module tb_reg_write_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 16;
  localparam int NREG = 6;
  localparam int AW = 3;
  typedef struct {
    int cyc;
    int ack_idx;
    int load_idx;
    int err;
    int wdata;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
`ifdef REG_ARB_LOCK_EN
  logic [NREQ-1:0] lock = '0;
`endif
  logic [NREQ-1:0] ack;
  logic [NREG-1:0] load;
  logic [WIDTH-1:0] wdata;
  logic err, busy;
  int total = 0, bad = 0, cyc = 0;
  exp_t sb[$];
  int log_idx[$];
  int log_cyc[$];
  int m_busy = 0, m_ptr = 0, m_win = 0, m_wdata = 0;

  reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .req_i  (req),
    .addr_i (addr),
    .data_i (data),
`ifdef REG_ARB_LOCK_EN
    .lock_i (lock),
`endif
    .ack_o  (ack),
    .load_o (load),
    .wdata_o(wdata),
    .err_o  (err),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic put(input int r, input int a, input int d);
    req[r] = 1'b1;
    addr[r*AW +: AW] = AW'(a);
    data[r*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  task automatic wait_ack(input int r);
    int got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (ack[r]) got = 1;
    end
    chk($sformatf("ack_wait_%0d", r), got, 1);
  endtask

  // Reference model: one write per grant, round-robin from the pointer, pointer moves after the write.
  initial begin
    exp_t e;
    int w, a, keep;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy = 0;
        m_ptr = 0;
        m_wdata = 0;
      end else if (m_busy != 0) begin
        m_busy = 0;
        keep = 0;
`ifdef REG_ARB_LOCK_EN
        keep = (lock[m_win] && req[m_win]) ? 1 : 0;
`endif
        m_ptr = (keep != 0) ? m_win : (m_win + 1) % NREQ;
      end else if (req != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        a = int'(addr[w*AW +: AW]);
        e.cyc = cyc;
        e.ack_idx = w;
        e.load_idx = (a < NREG) ? a : -1;
        e.err = (a < NREG) ? 0 : 1;
        if (a < NREG) m_wdata = int'(data[w*WIDTH +: WIDTH]);
        e.wdata = m_wdata;
        sb.push_back(e);
        m_busy = 1;
        m_win = w;
      end
    end
  end

  // Monitor: pops an expected write whenever the DUT presents one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack != '0 || load != '0 || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", int'(ack), 0);
        end else begin
          e = sb.pop_front();
          chk("ack", int'(ack), 1 << e.ack_idx);
          chk("load", int'(load), (e.load_idx < 0) ? 0 : (1 << e.load_idx));
          chk("err", int'(err), e.err);
          chk("wdata", int'(wdata), e.wdata);
          chk("busy_write", int'(busy), 1);
          chk("write_cycle", cyc, e.cyc);
          log_idx.push_back(e.ack_idx);
          log_cyc.push_back(cyc);
        end
      end else begin
        chk("busy_idle", int'(busy), 0);
        chk("wdata_hold", int'(wdata), m_wdata);
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          chk("missed_write", -1, e.ack_idx);
        end
      end
    end
  end

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wdata", int'(wdata), 0);
    rst = 0;
    @(negedge clk);
    put(0, 3, 'hBEEF);
    wait_ack(0);
    chk("t1_load", int'(load), 'h08);
    chk("t1_wdata", int'(wdata), 'hBEEF);
    chk("t1_ack", int'(ack), 1);
    req[0] = 0;
    @(negedge clk);
    chk("t1_idle", int'(busy), 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    log_idx.delete();
    log_cyc.delete();
    for (int r = 0; r < NREQ; r++) put(r, r, 'hA000 + r);
    repeat (10) @(negedge clk);
    req = '0;
    chk("t2_count", log_idx.size() >= 5 ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_grant%0d", i), log_idx[i], i % NREQ);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_gap%0d", i), log_cyc[i+1] - log_cyc[i], 2);
    repeat (3) @(negedge clk);
    put(2, 7, 'h1234);
    wait_ack(2);
    chk("t3_err", int'(err), 1);
    chk("t3_load", int'(load), 0);
    chk("t3_wdata", int'(wdata), 'hA000);
    req[2] = 0;
    n0 = log_idx.size();
    put(0, 0, 'h10);
    put(1, 1, 'h11);
    put(3, 3, 'h13);
    wait_ack(3);
    chk("t3_ptr_adv", log_idx[n0], 3);
    req = '0;
    repeat (3) @(negedge clk);
    put(1, 2, 'h5555);
    wait_ack(1);
    rst = 1;
    put(3, 4, 'h7777);
    @(negedge clk);
    chk("t4_ack", int'(ack), 0);
    chk("t4_load", int'(load), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_wdata", int'(wdata), 0);
    rst = 0;
    n0 = log_idx.size();
    wait_ack(1);
    chk("t4_reserve", log_idx[n0], 1);
    chk("t4_load2", int'(load), 'h04);
    chk("t4_wdata2", int'(wdata), 'h5555);
    req[1] = 0;
    wait_ack(3);
    req[3] = 0;
    repeat (3) @(negedge clk);
    put(0, 1, 'h1111);
    wait_ack(0);
    req[0] = 0;
    put(1, 5, 'h2222);
    @(negedge clk);
    req[1] = 0;
    n0 = log_idx.size();
    repeat (5) @(negedge clk);
    chk("t5_withdraw", log_idx.size(), n0);
`ifdef REG_ARB_LOCK_EN
    lock[2] = 1;
    put(1, 1, 'h0101);
    put(2, 2, 'h0202);
    for (int i = 0; i < 3; i++) begin
      n0 = log_idx.size();
      wait_ack(2);
      chk($sformatf("t6_locked%0d", i), log_idx[n0], 2);
    end
    lock[2] = 0;
    n0 = log_idx.size();
    wait_ack(1);
    chk("t6_unlock", log_idx[n0], 1);
    req = '0;
    repeat (3) @(negedge clk);
`endif
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
`ifdef REG_ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
`endif
      for (int r = 0; r < NREQ; r++) begin
        if (req[r] && ack[r]) begin
          if ($urandom_range(0, 1) == 0) req[r] = 0;
          else put(r, $urandom_range(0, 7), $urandom);
        end else if (!req[r]) begin
          if ($urandom_range(0, 3) == 0) put(r, $urandom_range(0, 7), $urandom);
        end else if ($urandom_range(0, 39) == 0) begin
          req[r] = 0;
        end
      end
    end
    rst = 0;
    req = '0;
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
